// File: rtl/mult_shift_pipe_pkg.sv
// rtl/mult_shift_pipe_pkg.sv - opcode encoding and sizing helpers for the multiply/shift pipe
package mult_shift_pipe_pkg;

    typedef enum logic [3:0] {
        OP_MULLU  = 4'd0,
        OP_MULLS  = 4'd1,
        OP_MULHU  = 4'd2,
        OP_MULHS  = 4'd3,
        OP_MULSAT = 4'd4,
        OP_SLL    = 4'd8,
        OP_SRL    = 4'd9,
        OP_SRA    = 4'd10,
        OP_ROL    = 4'd11,
        OP_ROR    = 4'd12
    } opcode_msp_t;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/msp_out_fifo.sv
// rtl/msp_out_fifo.sv - result FIFO, pointers wrap modulo DEPTH (any DEPTH >= 2)
module msp_out_fifo #(
    parameter int DW    = 33,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic [DW-1:0]                pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/mult_shift_pipe.sv
// rtl/mult_shift_pipe.sv - pipelined multiply/shift/rotate unit with credit-checked output FIFO
// Optional sticky overflow flag: define MULT_SHIFT_SAT_FLAG_EN.
module mult_shift_pipe
    import mult_shift_pipe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_LAT   = 3,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             I_Active,
    input  logic [3:0]       I_Opcode,
    input  logic             I_ValidA,
    input  logic [WIDTH-1:0] I_DataA,
    input  logic             I_RlsA,
    input  logic             I_ValidB,
    input  logic [WIDTH-1:0] I_DataB,
    output logic             O_NackA,
    output logic             O_NackB,
    output logic             O_Valid,
    output logic [WIDTH-1:0] O_Data,
    output logic             O_Rls,
`ifdef MULT_SHIFT_SAT_FLAG_EN
    output logic             O_SatFlag,
    input  logic             I_SatClr,
`endif
    input  logic             I_Nack
);
    localparam int AW = $clog2(WIDTH);
    localparam int CW = credit_width(OUT_DEPTH);

    logic                   fire, pop;
    logic [CW-1:0]          used_q, used_d;
    logic [2*WIDTH-1:0]     prod_u;
    logic signed [2*WIDTH-1:0] prod_s;
    logic                   s_ovf;
    logic [AW-1:0]          amt;
    logic [AW:0]            amt_inv;
    logic [WIDTH-1:0]       result;
    logic [WIDTH:0]         pipe_data_q [MUL_LAT];
    logic [WIDTH:0]         pipe_data_d [MUL_LAT];
    logic [MUL_LAT-1:0]     pipe_vld_q, pipe_vld_d;
    logic [WIDTH:0]         head;
    logic [CW-1:0]          fifo_count;

    // used_q counts in-flight plus buffered results; a pop only frees its slot next cycle.
    assign fire    = I_Active && I_ValidA && I_ValidB && (used_q < CW'(OUT_DEPTH));
    assign O_NackA = I_ValidA && !fire;
    assign O_NackB = I_ValidB && !fire;
    assign pop     = O_Valid && !I_Nack;

    always_comb begin
        prod_u  = {{WIDTH{1'b0}}, I_DataA} * {{WIDTH{1'b0}}, I_DataB};
        prod_s  = $signed({{WIDTH{I_DataA[WIDTH-1]}}, I_DataA}) *
                  $signed({{WIDTH{I_DataB[WIDTH-1]}}, I_DataB});
        s_ovf   = (|prod_s[2*WIDTH-1:WIDTH-1]) && !(&prod_s[2*WIDTH-1:WIDTH-1]);
        amt     = I_DataB[AW-1:0];
        amt_inv = (AW+1)'(WIDTH) - {1'b0, amt};
        result  = '0;
        case (I_Opcode)
            OP_MULLU:  result = prod_u[WIDTH-1:0];
            OP_MULLS:  result = prod_s[WIDTH-1:0];
            OP_MULHU:  result = prod_u[2*WIDTH-1:WIDTH];
            OP_MULHS:  result = prod_s[2*WIDTH-1:WIDTH];
            OP_MULSAT: result = !s_ovf ? prod_s[WIDTH-1:0] :
                                prod_s[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                  : {1'b0, {(WIDTH-1){1'b1}}};
            OP_SLL:    result = I_DataA << amt;
            OP_SRL:    result = I_DataA >> amt;
            OP_SRA:    result = WIDTH'($signed(I_DataA) >>> amt);
            // Shifting by WIDTH yields zero, so amount 0 rotates to A itself.
            OP_ROL:    result = (I_DataA << amt) | (I_DataA >> amt_inv);
            OP_ROR:    result = (I_DataA >> amt) | (I_DataA << amt_inv);
            default:   result = '0;
        endcase
    end

    always_comb begin
        pipe_vld_d[0]  = fire;
        pipe_data_d[0] = {I_RlsA, result};
        for (int i = 1; i < MUL_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
        used_d = used_q;
        if (fire && !pop) begin
            used_d = used_q + 1'b1;
        end else if (!fire && pop) begin
            used_d = used_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_vld_q <= '0;
            used_q     <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q  <= pipe_vld_d;
            used_q      <= used_d;
            pipe_data_q <= pipe_data_d;
        end
    end

    msp_out_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clock),
        .rst_n     (reset),
        .push      (pipe_vld_q[MUL_LAT-1]),
        .push_data (pipe_data_q[MUL_LAT-1]),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    assign O_Valid = (fifo_count != '0);
    assign O_Data  = O_Valid ? head[WIDTH-1:0] : '0;
    assign O_Rls   = O_Valid && head[WIDTH];

`ifdef MULT_SHIFT_SAT_FLAG_EN
    logic mul_ovf;
    logic sat_q, sat_d;

    always_comb begin
        mul_ovf = 1'b0;
        case (I_Opcode)
            OP_MULLU:             mul_ovf = |prod_u[2*WIDTH-1:WIDTH];
            OP_MULLS, OP_MULSAT:  mul_ovf = s_ovf;
            default:              mul_ovf = 1'b0;
        endcase
        sat_d = I_SatClr ? 1'b0 : (sat_q || (fire && mul_ovf));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign O_SatFlag = sat_q;
`endif

endmodule
